// File: rtl/branch_hist_table.sv
// branch_hist_table: direct-mapped branch history table of 2-bit saturating
// counters indexed by pc[IDX_W+1:2]. A lookup returns a registered
// taken/not-taken prediction one cycle later; resolved outcomes from execute
// train the counters.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset (counters -> 01, outputs -> 0)
//   valid_i      lookup request
//   pc_i         lookup PC
//   upd_valid_i  resolved-branch update
//   upd_pc_i     PC of resolved branch
//   upd_taken_i  resolved outcome (1 = taken)
//   valid_o      registered valid_i
//   taken_o      registered prediction (counter MSB, 0 when no lookup)
//
// Optional feature: define BHT_BYPASS_EN to forward a same-cycle update to a
// lookup of the same index (prediction reflects the post-update counter).
// Without it the lookup sees the pre-update counter.

module branch_hist_table #(
   parameter int unsigned LEN    = 128,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   output logic              valid_o,
   output logic              taken_o
);

   localparam int unsigned IDX_W = $clog2(LEN);
   localparam logic [1:0]  CNT_RESET = 2'b01;

   logic [1:0]       cnt [LEN];
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_cur;
   logic [1:0]       upd_nxt;
   logic [1:0]       rd_cnt;

   // Word-aligned index; low byte-offset bits and high PC bits alias.
   assign lk_idx  = pc_i[IDX_W+1:2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];

   // Bits intentionally ignored by the indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_i[ADDR_W-1:IDX_W+2], pc_i[1:0],
                             upd_pc_i[ADDR_W-1:IDX_W+2], upd_pc_i[1:0]};

   // Saturating counter step for the entry being trained.
   always_comb begin
      upd_cur = cnt[upd_idx];
      upd_nxt = upd_cur;
      if (upd_taken_i) begin
         if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'd1;
      end else begin
         if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'd1;
      end
   end

   // Lookup read, optionally forwarding a colliding update.
   always_comb begin
      rd_cnt = cnt[lk_idx];
`ifdef BHT_BYPASS_EN
      if (upd_valid_i && (upd_idx == lk_idx)) rd_cnt = upd_nxt;
`endif
   end

   // Counter array and registered prediction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(LEN); i++) cnt[i] <= CNT_RESET;
         valid_o <= 1'b0;
         taken_o <= 1'b0;
      end else begin
         if (upd_valid_i) cnt[upd_idx] <= upd_nxt;
         valid_o <= valid_i;
         taken_o <= valid_i & rd_cnt[1];
      end
   end

endmodule

// File: tb/tb_branch_hist_table.sv
module tb_branch_hist_table;

   typedef struct {
      logic ev;
      logic et;
      int   id;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [31:0] pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        valid_o;
   logic        taken_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_id  = 0;

`ifdef BHT_BYPASS_EN
   localparam logic COLL_EXP = 1'b1;
`else
   localparam logic COLL_EXP = 1'b0;
`endif

   branch_hist_table #(.LEN(128), .ADDR_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .valid_i     (valid),
      .pc_i        (pc),
      .upd_valid_i (upd_valid),
      .upd_pc_i    (upd_pc),
      .upd_taken_i (upd_taken),
      .valid_o     (valid_o),
      .taken_o     (taken_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: each edge's outputs are compared on the following falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (valid_o === e.ev && taken_o === e.et) n_pass++;
         else $display("FAIL step %0d: valid/taken got %b/%b want %b/%b",
                       e.id, valid_o, taken_o, e.ev, e.et);
      end
   end

   // One cycle of stimulus plus the expected outputs after the next edge.
   task automatic step(input logic r, input logic v, input logic [31:0] p,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic ev, input logic et);
      exp_t e;
      rst = r; valid = v; pc = p;
      upd_valid = uv; upd_pc = up; upd_taken = ut;
      e.ev = ev; e.et = et; e.id = step_id;
      exp_q.push_back(e);
      step_id++;
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] p, input logic et);
      step(1'b0, 1'b1, p, 1'b0, 32'h0, 1'b0, 1'b1, et);
   endtask

   task automatic update(input logic [31:0] up, input logic t);
      step(1'b0, 1'b0, 32'h0, 1'b1, up, t, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset for two cycles; the second carries a lookup and a taken
      // update to 0x4 that must both be discarded.
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h4, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
      lookup(32'h0,   1'b0);
      lookup(32'h4,   1'b0);
      lookup(32'h1FC, 1'b0);

      // Saturation up at 0x40: 01 -> 11 (saturates), then 10, then 01.
      update(32'h40, 1'b1);
      update(32'h40, 1'b1);
      update(32'h40, 1'b1);
      lookup(32'h40, 1'b1);
      update(32'h40, 1'b0);
      lookup(32'h40, 1'b1);
      update(32'h40, 1'b0);
      lookup(32'h40, 1'b0);

      // Saturation down at 0x80: 01 -> 00 (saturates), then 01, then 10.
      update(32'h80, 1'b0);
      update(32'h80, 1'b0);
      update(32'h80, 1'b0);
      update(32'h80, 1'b1);
      lookup(32'h80, 1'b0);
      update(32'h80, 1'b1);
      lookup(32'h80, 1'b1);

      // Aliasing: 0x204 and 0x7 share index 1 with 0x4; 0x8 is index 2.
      update(32'h4, 1'b1);
      update(32'h4, 1'b1);
      lookup(32'h204, 1'b1);
      lookup(32'h7,   1'b1);
      lookup(32'h8,   1'b0);

      // Different-index lookup and update in one cycle: 0x80 is 10,
      // 0x40 goes 01 -> 00.
      step(1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
      lookup(32'h40, 1'b0);

      // Same-index collision at 0x10 (01) with a taken update.
      step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 1'b1, COLL_EXP);
      lookup(32'h10, 1'b1);

      // Idle cycle: no lookup means taken_o is 0 even for a taken entry.
      step(1'b0, 1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Reset mid-operation with an in-flight lookup of a strong-taken entry.
      update(32'h20, 1'b1);
      update(32'h20, 1'b1);
      lookup(32'h20, 1'b1);
      step(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      lookup(32'h20, 1'b0);
      lookup(32'h40, 1'b0);

      // Drain the scoreboard with a bounded wait.
      rst = 1'b0; valid = 1'b0; upd_valid = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
